adc_xy_capture: RTL
===================

# adc_xy_capture

Capture sequencer for the XY/colour sample stream leaving the ADC clock-domain crossing. Arms on command, waits for the beam to turn on (any colour bit set), records a fixed-length burst of samples (optionally decimated) into an internal buffer, then drains the burst downstream over a valid/ready stream. It sits entirely in the main clock domain, between the ADC sample path and the consumer (display or debug readout), and gives software a clean, triggered snapshot of a free-running source that never stalls.

## Interface
- DATA_BITS, 10, width of each of x and y
- DEPTH, 256, samples per burst; power of 2, ≥ 4
- DECIM_BITS, 8, width of the decimation ratio input

- clk  in  1  main system clock; the only clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle arm request; honoured only in IDLE
- abort  in  1  single-cycle cancel; honoured in every state
- decim  in  DECIM_BITS  keep 1 of every decim+1 samples; sampled on accepted start
- s_valid  in  1  a new sample is present this cycle; no back-pressure
- s_x, s_y  in  DATA_BITS  sample coordinates
- s_red, s_grn, s_blu  in  1  sample colour bits
- m_valid  out  1  drain word valid
- m_ready  in  1  consumer accepts the word
- m_data  out  2*DATA_BITS+3  {x, y, red, grn, blu}
- m_last  out  1  qualifies the final word of the burst
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE: an accepted start loads decim into an internal register, clears the write pointer, and moves to ARMED.
- ARMED: trigger is s_valid with {s_red, s_grn, s_blu} != 0. The trigger sample is written to address 0, the decimation counter is loaded with decim, and the state moves to CAPTURE. Samples with no colour bit set are discarded.
- CAPTURE: each s_valid decrements the decimation counter. When the counter is 0, the sample is written and the counter reloads with decim. After write DEPTH-1, the state moves to DRAIN. Samples arriving in DRAIN or IDLE are ignored.
- DRAIN: reads addresses 0..DEPTH-1 in order.
  - A word transfers on m_valid && m_ready.
  - m_data, m_last and m_valid stay stable while m_valid && !m_ready.
  - m_last is high only with word DEPTH-1.
  - Transfer of the last word leads to IDLE with done=1 for one cycle.
- abort: moves to IDLE on the next edge from any state and discards buffered data. m_valid drops immediately, even mid-handshake. done does not pulse. abort wins over a simultaneous start or trigger.
- start outside IDLE is ignored. start and abort in the same cycle as IDLE → stays IDLE.
- The buffer is a synchronous-read RAM (one BRAM-mappable array). Read is prefetched so that drain sustains 1 word per cycle while m_ready is held high.
- Pointer widths are $clog2(DEPTH). The pointers do not wrap within a burst; the write count ends at exactly DEPTH.

## Timing
- Reset values: state IDLE, busy=0, m_valid=0, m_last=0, done=0, m_data=0, decim register=0.
- start in cycle N → busy=1 in N+1.
- Trigger sample in cycle T → written at T and CAPTURE entered at T+1.
- Last capture write in cycle L → DRAIN at L+1 and m_valid=1 first at L+2.
- With m_ready held high, words appear on consecutive cycles L+2 .. L+1+DEPTH. done=1 at L+2+DEPTH, busy=0 in the same cycle.
- A new start is accepted in the cycle done is high.

## Configuration
- ADC_XY_CAPTURE_DECIM_EN: when defined, decimation operates as described.
- When undefined, the decim input is ignored: no register and no counter are built, and every s_valid in CAPTURE is written (behaves as decim=0).

## Test plan
- Basic burst: DEPTH=8, decim=0. Start, then 3 dark samples, then 8 lit samples x=0..7 → buffer holds x=0..7. With m_ready=1, words x=0..7 arrive on 8 consecutive cycles, m_last with x=7, then done for one cycle.
- Back-pressure: same capture, with m_ready toggling 1,0,0,1,… → each word held stable while stalled, no word lost or repeated, m_last only on x=7.
- Decimation (macro on): decim=2, lit samples x=0..23 continuous → captured x=0,3,6,…,21. Macro off, same stimulus → x=0..7.
- Sparse valid: s_valid every 3rd cycle during CAPTURE → only valid samples counted. m_valid first asserts exactly 2 cycles after the 8th write.
- Abort: abort in ARMED, abort mid-CAPTURE (after 4 writes), and abort mid-DRAIN with m_valid=1, m_ready=0 → IDLE next cycle, m_valid=0, busy=0, no done. A following full burst is correct.
- Edge cases:
  - start while busy is ignored.
  - start and abort in the same cycle → stays IDLE.
  - reset asserted mid-DRAIN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/adc_xy_capture_if.sv
// ----------------------------------------------------------------------------
// adc_xy_capture_if
//   Drain stream from the capture buffer to its consumer. A word moves on
//   m_valid && m_ready, and m_last marks the final word of a burst.
//
//   m_valid  master -> slave  drain word valid
//   m_ready  slave -> master  consumer accepts the word
//   m_data   master -> slave  {x, y, red, grn, blu}
//   m_last   master -> slave  final word of the burst
// ----------------------------------------------------------------------------
interface adc_xy_capture_if #(
    parameter int DATA_BITS = 10
);
    logic                   m_valid;
    logic                   m_ready;
    logic [2*DATA_BITS+2:0] m_data;
    logic                   m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/adc_xy_capture.sv
// ----------------------------------------------------------------------------
// adc_xy_capture
//   Triggered snapshot of the free-running XY/colour sample stream. The block
//   arms on start, waits for the beam to turn on (any colour bit set), records
//   DEPTH samples (optionally keeping 1 of every decim+1) into a block-RAM
//   buffer, then drains the burst over a valid/ready stream.
//
//   Optional feature: define ADC_XY_CAPTURE_DECIM_EN to build the decimation
//   register and counter. Without it, decim is ignored and every valid sample
//   in CAPTURE is stored.
//
//   clk                     main clock (the only clock)
//   reset                   synchronous, active-high
//   start                   one-cycle arm request, honoured only in IDLE
//   abort                   one-cycle cancel, honoured in every state
//   decim                   decimation ratio, sampled on an accepted start
//   s_valid, s_x, s_y,
//   s_red, s_grn, s_blu     incoming sample stream, no back-pressure
//   drain                   master side of the drain stream
//   busy                    high in any state but IDLE
//   done                    one-cycle pulse after the last word is accepted
// ----------------------------------------------------------------------------
module adc_xy_capture #(
    parameter int DATA_BITS  = 10,
    parameter int DEPTH      = 256,
    parameter int DECIM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DECIM_BITS-1:0] decim,
    input  logic                  s_valid,
    input  logic [DATA_BITS-1:0]  s_x,
    input  logic [DATA_BITS-1:0]  s_y,
    input  logic                  s_red,
    input  logic                  s_grn,
    input  logic                  s_blu,
    adc_xy_capture_if.master      drain,
    output logic                  busy,
    output logic                  done
);
    localparam int              AW        = $clog2(DEPTH);
    localparam int              WW        = 2*DATA_BITS + 3;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t        state, state_next;
    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [WW-1:0] sample;
    logic          lit;
    logic          keep;
    logic          wr_en;
    logic          trigger;
    logic          rd_load;
    logic          last_xfer;

    assign sample = {s_x, s_y, s_red, s_grn, s_blu};
    assign lit    = s_red | s_grn | s_blu;
    assign busy   = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        trigger    = 1'b0;
        rd_load    = 1'b0;
        last_xfer  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ARMED;
            end
            ARMED: begin
                if (s_valid && lit) begin
                    wr_en      = 1'b1;
                    trigger    = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (s_valid && keep) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_ADDR) state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Fetch the next word whenever the output register is empty
                // or being emptied this cycle; stop once the last word is held.
                rd_load = !(drain.m_valid && drain.m_last) &&
                          (!drain.m_valid || drain.m_ready);
                if (drain.m_valid && drain.m_ready && drain.m_last) begin
                    last_xfer  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // abort beats start, trigger and the final transfer alike.
        if (abort) begin
            state_next = IDLE;
            wr_en      = 1'b0;
            trigger    = 1'b0;
            rd_load    = 1'b0;
            last_xfer  = 1'b0;
        end
    end

`ifdef ADC_XY_CAPTURE_DECIM_EN
    logic [DECIM_BITS-1:0] decim_q;
    logic [DECIM_BITS-1:0] dec_cnt;

    assign keep = (dec_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            decim_q <= '0;
            dec_cnt <= '0;
        end else begin
            if (state == IDLE && start && !abort) decim_q <= decim;
            if (trigger)
                dec_cnt <= decim_q;
            else if (state == CAPTURE && s_valid && !abort)
                dec_cnt <= keep ? decim_q : dec_cnt - DECIM_BITS'(1);
        end
    end
`else
    logic unused_decim;
    assign unused_decim = ^decim;
    assign keep         = 1'b1;
`endif

    // NOTE: the buffer has no reset so it maps onto block RAM; drain only
    // ever follows a complete burst, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sample;
    end

    // Synchronous read straight into the output data register; holding the
    // read enable low while stalled keeps m_data stable.
    always_ff @(posedge clk) begin
        if (reset)        drain.m_data <= '0;
        else if (rd_load) drain.m_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            drain.m_valid <= 1'b0;
            drain.m_last  <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= last_xfer;

            // Write pointer rests at 0 in IDLE so each burst starts at address 0.
            if (state == IDLE) wr_ptr <= '0;
            else if (wr_en)    wr_ptr <= wr_ptr + AW'(1);

            if (state != DRAIN || abort) begin
                rd_ptr        <= '0;
                drain.m_valid <= 1'b0;
                drain.m_last  <= 1'b0;
            end else if (rd_load) begin
                rd_ptr        <= rd_ptr + AW'(1);
                drain.m_valid <= 1'b1;
                drain.m_last  <= (rd_ptr == LAST_ADDR);
            end else if (drain.m_ready) begin
                drain.m_valid <= 1'b0;
                drain.m_last  <= 1'b0;
            end
        end
    end
endmodule
